// File: rtl/kf_seq_if.sv
// Operand stream carrying external values into the kf_core Data Bank.
// A beat transfers on a rising clk edge where in_valid and in_ready are both high.
interface kf_seq_if #(
    parameter int W = 24
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/kf_seq.sv
// Microcode sequencer driving kf_core: fetches instructions from a loadable program
// memory, issues AU ops, waits for au_done, and writes results/operands into the Data Bank.
module kf_seq #(
    parameter int W      = 24,
    parameter int ADDRW  = 6,
    parameter int PDEPTH = 64,
    parameter int PADDRW = 6,
    parameter int IW     = 40,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [PADDRW-1:0] prog_addr,
    input  logic [IW-1:0]     prog_wdata,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PADDRW-1:0] pc,
    kf_seq_if.slave           opnd,
    output logic [W-1:0]      DATA_IN,
    output logic [ADDRW-1:0]  CTL_A,
    output logic [ADDRW-1:0]  CTL_B,
    output logic [ADDRW-1:0]  DB_WADDR,
    output logic [ADDRW-1:0]  DIR_EXT,
    output logic              WRITE_REQ,
    output logic              READY_G,
    output logic              sel_dira,
    output logic              sel_dirb,
    output logic [1:0]        sel_data,
    output logic [1:0]        sel_write,
    output logic [1:0]        sel_R,
    output logic [1:0]        sel_S,
    output logic [1:0]        sel_I,
    output logic              inv_R,
    output logic              inv_S,
    output logic              au_start,
    output logic [1:0]        op_sel,
    output logic [1:0]        mul_y_sel,
    input  logic              au_done,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DISPATCH, S_ISSUE, S_WAIT, S_LOADW, S_WB, S_NEXT, S_FIN
    } state_t;

    localparam logic [1:0] C_AU   = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_ZERO = 2'b10;

    localparam int                WDW     = $clog2(TMO + 1);
    localparam logic [WDW-1:0]    WD_LAST = WDW'(TMO - 1);
    localparam logic [PADDRW-1:0] PC_LAST = PADDRW'(PDEPTH - 1);

    state_t            state_q, state_d;
    logic [PADDRW-1:0] pc_q;
    logic [IW-1:0]     ir_q;
    logic              err_q;
    logic [WDW-1:0]    wd_q;
    logic [IW-1:0]     pmem [PDEPTH];
    logic              kill;
    logic              in_ready_c, write_c, au_start_c, done_c;
    logic              unused_rsvd;

    assign kill = abort && (state_q != S_IDLE);

    // Program memory can only change while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == S_IDLE) pmem[prog_addr] <= prog_wdata;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        write_c    = 1'b0;
        au_start_c = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH:    state_d = S_DISPATCH;
            S_DISPATCH: begin
                case (ir_q[39:38])
                    C_AU:    state_d = S_ISSUE;
                    C_LOAD:  state_d = S_LOADW;
                    C_ZERO:  state_d = S_WB;
                    default: state_d = S_FIN;
                endcase
            end
            S_ISSUE: begin
                au_start_c = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (au_done)             state_d = S_WB;
                else if (wd_q == WD_LAST) state_d = S_FIN;
            end
            S_LOADW: begin
                in_ready_c = 1'b1;
                if (opnd.in_valid) begin
                    write_c = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_WB: begin
                write_c = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: state_d = (pc_q == PC_LAST) ? S_FIN : S_FETCH;
            S_FIN: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort squashes every side effect of the current cycle, including handshakes.
        if (kill) begin
            state_d    = S_IDLE;
            in_ready_c = 1'b0;
            write_c    = 1'b0;
            au_start_c = 1'b0;
            done_c     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (!kill) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            pc_q  <= '0;
                            err_q <= 1'b0;
                        end
                    end
                    S_FETCH: ir_q <= pmem[pc_q];
                    S_ISSUE: wd_q <= '0;
                    S_WAIT: begin
                        if (!au_done) begin
                            wd_q <= wd_q + 1'b1;
                            if (wd_q == WD_LAST) err_q <= 1'b1;
                        end
                    end
                    S_NEXT: if (pc_q != PC_LAST) pc_q <= pc_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (ir_q[39:38])
            C_AU:    sel_data = 2'd1;
            C_LOAD:  sel_data = 2'd0;
            C_ZERO:  sel_data = 2'd2;
            default: sel_data = 2'd0;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_c;
    assign err           = err_q;
    assign pc            = pc_q;
    assign opnd.in_ready = in_ready_c;
    assign WRITE_REQ     = write_c;
    assign au_start      = au_start_c;
    assign dbg_state     = state_q;

    assign DATA_IN   = opnd.in_data;
    assign DB_WADDR  = ir_q[37:32];
    assign CTL_A     = ir_q[31:26];
    assign CTL_B     = ir_q[25:20];
    assign sel_R     = ir_q[19:18];
    assign sel_S     = ir_q[17:16];
    assign inv_R     = ir_q[15];
    assign inv_S     = ir_q[14];
    assign sel_I     = ir_q[13:12];
    assign op_sel    = ir_q[11:10];
    assign mul_y_sel = ir_q[9:8];

    assign DIR_EXT   = '0;
    assign sel_dira  = 1'b0;
    assign sel_dirb  = 1'b0;
    assign sel_write = 2'b00;
    assign READY_G   = 1'b1;

    assign unused_rsvd = ^ir_q[7:0];

endmodule
